// File: rtl/ir_receiver.sv
// Bus-mapped IR command receiver: decodes width-encoded mark/space trains into a command word.
// Optional glitch filter on the synchronised input is enabled by defining IR_RX_GLITCH_FILTER_EN.
module ir_receiver #(
  parameter logic [7:0] BASE_ADDR  = 8'hA0,
  parameter int         NBITS      = 4,
  parameter int         TICK_DIV   = 100,
  parameter int         START_MIN  = 2000,
  parameter int         BIT_MIN    = 200,
  parameter int         ONE_MIN    = 900,
  parameter int         GAP_MAX    = 3000,
  parameter int         MARK_MAX   = 5000,
  parameter int         FILTER_LEN = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  typedef enum logic [2:0] {IDLE, START, SPACE, BIT_MARK, DONE} state_t;

  state_t           state_q;
  logic             ir_s1_q, ir_s2_q, mark_prev_q, ir_clean;
  logic             mark_now, mark_start, mark_end, tick, err_evt;
  logic [15:0]      presc_q, presc_d, dur_q, dur_d;
  logic [2:0]       bit_idx_q;
  logic [NBITS-1:0] shreg_q, cmd_q;
  logic             valid_q, overrun_q, raise_q;
  logic [7:0]       pkt_cnt_q, err_cnt_q;
  logic [7:0]       addr_off, rd_data_q, rd_data_d;
  logic             rd_en_q, rd_en_d, in_range, wr0, wr2;

  // IR path idles high, so the synchroniser resets to the no-mark level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir_s1_q     <= 1'b1;
      ir_s2_q     <= 1'b1;
      mark_prev_q <= 1'b0;
    end else begin
      ir_s1_q     <= IR_IN;
      ir_s2_q     <= ir_s1_q;
      mark_prev_q <= mark_now;
    end
  end

`ifdef IR_RX_GLITCH_FILTER_EN
  logic        filt_q, filt_d;
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (ir_s2_q != filt_q) begin
      if (fcnt_q == 16'(FILTER_LEN - 1)) filt_d = ir_s2_q;
      else                                fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign ir_clean = filt_q;
`else
  assign ir_clean = ir_s2_q;
`endif

  assign mark_now   = ~ir_clean;
  assign mark_start = mark_now & ~mark_prev_q;
  assign mark_end   = ~mark_now & mark_prev_q;
  assign tick       = (presc_q == 16'(TICK_DIV - 1));

  assign addr_off = BUS_ADDR - BASE_ADDR;
  assign in_range = (addr_off < 8'd3);
  assign wr0      = in_range & BUS_WE & (addr_off == 8'd0);
  assign wr2      = in_range & BUS_WE & (addr_off == 8'd2);

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    dur_d   = dur_q;
    if (mark_start || mark_end)        dur_d = 16'd0;
    else if (tick && dur_q != 16'hFFFF) dur_d = dur_q + 16'd1;

    rd_en_d = in_range & ~BUS_WE;
    case (addr_off)
      8'd0:    rd_data_d = {valid_q, overrun_q, 6'(cmd_q)};
      8'd1:    rd_data_d = pkt_cnt_q;
      8'd2:    rd_data_d = err_cnt_q;
      default: rd_data_d = 8'h00;
    endcase

    // Edge strobes take priority over timeouts when both land in the same cycle.
    err_evt = ((state_q == SPACE) && !mark_start && (dur_q > 16'(GAP_MAX))) ||
              (((state_q == START) || (state_q == BIT_MARK)) && !mark_end && (dur_q > 16'(MARK_MAX))) ||
              ((state_q == BIT_MARK) && mark_end && (dur_q < 16'(BIT_MIN)));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q   <= '0;
      dur_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      presc_q   <= presc_d;
      dur_q     <= dur_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      raise_q   <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (wr0) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (BUS_INTERRUPT_ACK) raise_q <= 1'b0;
      if (err_evt)  err_cnt_q <= wr2 ? 8'd1 : ((err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1);
      else if (wr2) err_cnt_q <= 8'd0;

      case (state_q)
        IDLE: if (mark_start) state_q <= START;
        START: begin
          if (mark_end) begin
            state_q   <= (dur_q >= 16'(START_MIN)) ? SPACE : IDLE;
            bit_idx_q <= '0;
          end else if (dur_q > 16'(MARK_MAX)) begin
            state_q <= IDLE;
          end
        end
        SPACE: begin
          if (mark_start)                   state_q <= BIT_MARK;
          else if (dur_q > 16'(GAP_MAX))    state_q <= IDLE;
        end
        BIT_MARK: begin
          if (mark_end) begin
            if (dur_q < 16'(BIT_MIN)) begin
              state_q <= IDLE;
            end else begin
              for (int i = 0; i < NBITS; i++)
                if (bit_idx_q == 3'(i)) shreg_q[i] <= (dur_q >= 16'(ONE_MIN));
              if (bit_idx_q == 3'(NBITS - 1)) begin
                state_q <= DONE;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
                state_q   <= SPACE;
              end
            end
          end else if (dur_q > 16'(MARK_MAX)) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          // A new packet beats a coincident clear or acknowledge.
          cmd_q     <= shreg_q;
          valid_q   <= 1'b1;
          overrun_q <= ~wr0 & (overrun_q | valid_q);
          raise_q   <= 1'b1;
          pkt_cnt_q <= pkt_cnt_q + 8'd1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUS_INTERRUPT_RAISE = raise_q;
  assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_ir_receiver.sv
// Self-checking bench for ir_receiver: directed scenarios plus randomized packets
// compared against a packet-level reference model of the register state.
module tb_ir_receiver;
  localparam int         TD   = 4;
  localparam int         NB   = 4;
  localparam logic [7:0] BASE = 8'hA0;

  logic       clk = 1'b0, rst = 1'b1, ir_in = 1'b1, bus_we = 1'b0, ack = 1'b0, tb_drv = 1'b0;
  logic [7:0] bus_addr = 8'h00, tb_wdata = 8'h00;
  wire        raise;
  wire  [7:0] bus_data;

  int n_cmp = 0, n_bad = 0;
  logic       exp_valid, exp_ovr, exp_raise;
  logic [7:0] exp_cmd, exp_pkt, exp_err;

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (bus_data[gi]);
  end

  ir_receiver #(
    .BASE_ADDR(BASE), .NBITS(NB), .TICK_DIV(TD), .START_MIN(20), .BIT_MIN(6),
    .ONE_MIN(12), .GAP_MAX(30), .MARK_MAX(50), .FILTER_LEN(8)
  ) dut (
    .CLK(clk), .RESET(rst), .IR_IN(ir_in), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr),
    .BUS_WE(bus_we), .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic int urand(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ir_hold(input logic lvl, input int ticks);
    ir_in = lvl;
    cyc(ticks * TD);
  endtask

  task automatic rd(input logic [7:0] off, output logic [7:0] d);
    bus_addr = BASE + off; bus_we = 1'b0;
    @(posedge clk); #1;
    d = bus_data;
    bus_addr = 8'h00;
    cyc(1);
  endtask

  task automatic wr(input logic [7:0] off);
    bus_addr = BASE + off; bus_we = 1'b1; tb_drv = 1'b1; tb_wdata = 8'($urandom);
    @(posedge clk); #1;
    bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  // kind: 0 good, 1 short start, 2 short bit at pos, 3 long gap after bit pos,
  // 4 stuck bit mark at pos, 5 stuck start mark
  task automatic send(input logic [7:0] cmd, input int kind, input int pos);
    ir_hold(1'b0, (kind == 1) ? urand(5, 17) : (kind == 5) ? urand(54, 60) : urand(23, 30));
    if (kind == 1 || kind == 5) begin ir_in = 1'b1; return; end
    for (int b = 0; b < NB; b++) begin
      if (kind == 3 && b == pos + 1) begin ir_hold(1'b1, urand(34, 40)); return; end
      ir_hold(1'b1, urand(5, 27));
      if (kind == 2 && b == pos) begin ir_hold(1'b0, urand(3, 4)); ir_in = 1'b1; return; end
      if (kind == 4 && b == pos) begin ir_hold(1'b0, urand(54, 60)); ir_in = 1'b1; return; end
      ir_hold(1'b0, cmd[b] ? urand(14, 17) : urand(8, 10));
    end
    ir_in = 1'b1;
  endtask

  task automatic model_pkt(input logic [7:0] cmd, input int kind);
    if (kind == 0) begin
      exp_ovr   = exp_ovr | exp_valid;
      exp_valid = 1'b1;
      exp_cmd   = cmd & 8'h0F;
      exp_pkt   = exp_pkt + 8'd1;
      exp_raise = 1'b1;
    end else if (kind != 1) begin
      exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
    end
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_ovr = 0; exp_raise = 0; exp_cmd = 0; exp_pkt = 0; exp_err = 0;
  endtask

  task automatic wait_raise(input bit hold_ack, input bit hold_wr);
    int i = 0;
    while (raise !== 1'b1 && i < 24) begin
      ack = hold_ack;
      if (hold_wr) begin bus_addr = BASE; bus_we = 1'b1; tb_drv = 1'b1; end
      @(posedge clk); #1;
      ack = 1'b0; bus_we = 1'b0; tb_drv = 1'b0; bus_addr = 8'h00;
      i++;
    end
    check("raise_seen", 32'(raise), 32'd1);
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    check({tag, "_raise"}, 32'(raise), 32'(exp_raise));
    check({tag, "_busz"}, 32'(bus_data), 32'hFF);
    rd(8'd0, d); check({tag, "_stat"}, 32'(d), 32'({exp_valid, exp_ovr, exp_cmd[5:0]}));
    rd(8'd1, d); check({tag, "_pkt"}, 32'(d), 32'(exp_pkt));
    rd(8'd2, d); check({tag, "_err"}, 32'(d), 32'(exp_err));
  endtask

  initial begin
    int kind, pos;
    logic [7:0] cmd, d;
    model_reset();
    #23;
    check("rst_raise", 32'(raise), 32'd0);
    check("rst_busz", 32'(bus_data), 32'hFF);
    @(posedge clk); #1; rst = 1'b0;
    cyc(4);
    check_regs("reset");

    send(8'h5, 0, 0); wait_raise(0, 0); model_pkt(8'h5, 0); cyc(24);
    check_regs("good");
    pulse_ack(); exp_raise = 0; cyc(1);
    check("ack_clear", 32'(raise), 32'd0);

    send(8'h0, 1, 0); model_pkt(8'h0, 1); cyc(40);
    check_regs("short_start");

    send(8'h3, 3, 1); model_pkt(8'h3, 3); cyc(24);
    check_regs("timeout");

    wr(8'd0); exp_valid = 0; exp_ovr = 0;
    send(8'h5, 0, 0); wait_raise(0, 0); model_pkt(8'h5, 0); cyc(24);
    pulse_ack(); exp_raise = 0;
    send(8'hA, 0, 0); wait_raise(1, 0); model_pkt(8'hA, 0); cyc(24);
    check_regs("overrun");
    wr(8'd0); exp_valid = 0; exp_ovr = 0;
    rd(8'd0, d); check("clr_stat", 32'(d), 32'h0A);

    pulse_ack(); exp_raise = 0;
    send(8'h6, 0, 0); wait_raise(0, 1); model_pkt(8'h6, 0); cyc(24);
    check_regs("wr_vs_done");

    ir_hold(1'b0, 25); ir_hold(1'b1, 8); ir_hold(1'b0, 15); ir_hold(1'b1, 8);
    ir_hold(1'b0, 9); ir_hold(1'b1, 8); ir_in = 1'b0; cyc(10);
    #2 rst = 1'b1;
    #1 check("midrst_raise", 32'(raise), 32'd0);
    check("midrst_busz", 32'(bus_data), 32'hFF);
    model_reset();
    cyc(2); ir_in = 1'b1; cyc(2); rst = 1'b0; cyc(20);
    send(8'h3, 0, 0); wait_raise(0, 0); model_pkt(8'h3, 0); cyc(24);
    check_regs("after_rst");

    for (int it = 0; it < 30; it++) begin
      cmd  = 8'($urandom_range(15, 0));
      kind = ($urandom_range(1, 0) == 0) ? 0 : urand(1, 5);
      pos  = (kind == 3) ? urand(0, NB - 2) : urand(0, NB - 1);
      send(cmd, kind, pos);
      model_pkt(cmd, kind);
      cyc(24);
      check_regs($sformatf("rnd%0d_k%0d", it, kind));
      if ($urandom_range(1, 0) == 1) begin pulse_ack(); exp_raise = 0; end
      case ($urandom_range(5, 0))
        0, 1:    begin wr(8'd0); exp_valid = 0; exp_ovr = 0; end
        2:       begin wr(8'd2); exp_err = 0; end
        3:       wr(8'd1);
        default: ;
      endcase
      cyc(8);
    end
    check_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ir_receiver.md
Name: ir_receiver

Overview:
- Bus-mapped IR command receiver; the receive-side counterpart of the IR transmitter peripheral.
- Decodes demodulated IR mark/space pulse trains (start mark followed by NBITS data marks, width-encoded) into a command word.
- Raises an interrupt line to the processor and exposes status, command, packet count and error count on the shared 8-bit data bus.

Parameters:
- BASE_ADDR, 8'hA0, first of 3 consecutive bus addresses.
- NBITS, 4, data bits per packet; legal range 1..6.
- TICK_DIV, 100, CLK cycles per timing tick (1 us at 100 MHz).
- START_MIN, 2000, minimum start-mark length in ticks.
- BIT_MIN, 200, minimum data-mark length in ticks.
- ONE_MIN, 900, data mark of at least this many ticks decodes as 1; shorter decodes as 0.
- GAP_MAX, 3000, maximum space length in ticks before abort.
- MARK_MAX, 5000, maximum mark length in ticks before abort.
- FILTER_LEN, 8, glitch-filter stability length in CLK cycles (optional feature only).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- IR_IN  input  1  demodulated IR receiver output, active-low (low = mark), asynchronous.
- BUS_DATA  inout  8  shared data bus; high-Z unless this block is read.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write enable.
- BUS_INTERRUPT_RAISE  output  1  packet-received interrupt.
- BUS_INTERRUPT_ACK  input  1  processor acknowledge, one-cycle pulse.

Behaviour:
- Reset values: BUS_DATA Z, BUS_INTERRUPT_RAISE 0, all registers 0, FSM IDLE.
- Input path: IR_IN passes through a 2-FF synchroniser; mark = synced low. mark_start/mark_end are 1-cycle edge strobes.
- Tick prescaler: free-running counter 0..TICK_DIV-1. Duration counter is 16 bits, cleared on every edge strobe, increments on each tick, saturates at 16'hFFFF.
- FSM:
  - IDLE: on mark_start, go to START.
  - START: on mark_end, go to SPACE with bit_idx=0 if dur >= START_MIN; otherwise return to IDLE silently (noise, no error).
  - SPACE: on mark_start, go to BIT_MARK. If dur > GAP_MAX, go to IDLE and count an error.
  - BIT_MARK: on mark_end with dur < BIT_MIN, go to IDLE and count an error. Otherwise shift bit (dur >= ONE_MIN) into shreg[bit_idx] (LSB first). Go to DONE if bit_idx == NBITS-1, else go to SPACE and increment bit_idx.
  - START or BIT_MARK with dur > MARK_MAX: go to IDLE and count an error (stuck-low input).
  - DONE: lasts 1 cycle. If valid is already 1, set overrun. Then latch cmd = shreg, set valid = 1, set raise = 1, increment pkt_cnt (wraps 255 to 0). Return to IDLE.
- Error count: 8 bits, saturates at 255.
- Interrupt: set in DONE, cleared by BUS_INTERRUPT_ACK. If both occur in the same cycle, set wins.
- Register map:
  - BASE+0 read: {valid, overrun, cmd[5:0]}; unused cmd bits read 0. Any write clears valid and overrun.
  - BASE+1 read: pkt_cnt.
  - BASE+2 read: err_cnt. A write to BASE+2 clears err_cnt.
  - Writes to BASE+1 are ignored.
- Read timing: when BUS_ADDR is in range and BUS_WE=0 at edge N, this block drives BUS_DATA during cycle N+1 with registered data, then releases to high-Z. Reads have no side effects.
- Simultaneous events: a write clearing BASE+0 in the same cycle as DONE leaves valid=1 and overrun=0 (new packet wins).
- Reset mid-packet: FSM aborts immediately; nothing is latched.

Optional Feature:
- IR_RX_GLITCH_FILTER_EN defined: after the synchroniser, the filtered input changes only once the synced level has been stable for FILTER_LEN consecutive CLK cycles. This adds FILTER_LEN cycles of edge latency, and pulses shorter than FILTER_LEN are discarded.
- Undefined: the synchroniser output is used directly (2-cycle latency).

Test Plan:
- Reset: assert RESET mid-clock -> BUS_DATA Z, BUS_INTERRUPT_RAISE=0; reads of BASE+0/1/2 return 0x00.
- Good packet: start 2500 us; marks 1200/400/1200/400 us with 600 us spaces -> raise within 3 cycles of the last mark_end; BASE+0 reads 0x85; BASE+1 reads 0x01; ACK pulse clears raise.
- Short start: 1000 us mark, then idle -> no raise; err_cnt stays 0; FSM back in IDLE.
- Timeout: valid start, 2 bits, then 3500 us space -> err_cnt=1, no raise, BASE+0 unchanged.
- Overrun: two good packets (0x5, then 0xA) with no clear -> BASE+0 reads 0xCA; write BASE+0 -> reads 0x0A; ACK coincident with the second DONE -> raise stays 1.
- Reset mid-packet after 2 bits, then a good 0x3 packet -> BASE+0 reads 0x83; pkt_cnt=1.
